// File: rtl/pts_tx_pkg.sv
// Shared types and constants for the parallel-to-serial frame transmitter.
// Imported by the bit timer and the top-level FSM.
package pts_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pts_frame_tx_bit_timer.sv
// Per-bit cycle counter: runs 0..CLKS_PER_BIT-1 while a frame is active,
// and flags the last cycle of each serial bit.
module bit_timer
    import pts_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_done
);

    localparam int CNT_W = width_for(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = run && (count == LAST);

endmodule

// File: rtl/pts_frame_tx.sv
// Frame transmitter: start bit, DATA_W data bits LSB-first, optional parity,
// one or two stop bits; back-to-back frames accepted in the last stop cycle.
module pts_frame_tx
    import pts_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              data_strobe
);

    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("pts_frame_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 1) begin : g_bad_data_w
        $error("pts_frame_tx: DATA_W must be >= 1");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("pts_frame_tx: CLKS_PER_BIT must be >= 1");
    end

    localparam int IDX_W = width_for(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    tx_state_t         state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [IDX_W-1:0]  bit_idx, bit_idx_next;
    logic              stop_idx, stop_idx_next;
    logic              parity_q, parity_next;
    logic              line_next;
    logic              bit_done;
    logic              accept;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (busy),
        .bit_done(bit_done)
    );

    assign busy        = (state != IDLE);
    assign tx_ready    = (state == IDLE) ||
                         (state == STOP && bit_done && stop_idx == LAST_STOP);
    assign accept      = tx_valid && tx_ready;
    assign data_strobe = (state == DATA) && bit_done;

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        parity_next   = parity_q;

        // Accept only happens in IDLE or the final stop cycle, where the
        // shift register and parity are otherwise idle.
        if (accept) begin
            shreg_next  = tx_data;
            parity_next = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
        end

        unique case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_next = shreg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_next    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_idx_next = 1'b0;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next    = STOP;
                    stop_idx_next = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx == LAST_STOP) begin
                        state_next = accept ? START : IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is registered alongside the state it belongs to.
        unique case (state_next)
            START:   line_next = START_LVL;
            DATA:    line_next = shreg_next[0];
            PARITY:  line_next = parity_next;
            default: line_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_q   <= 1'b0;
            serial_out <= LINE_IDLE;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_idx    <= bit_idx_next;
            stop_idx   <= stop_idx_next;
            parity_q   <= parity_next;
            serial_out <= line_next;
        end
    end

endmodule

// File: tb/tb_pts_frame_tx.sv
// Bench for pts_frame_tx: several parameterisations driven with random words
// and compared cycle by cycle against a frame model built from the bit layout.
module tb_pts_frame_tx;

    localparam int NI = 5;
    localparam int CFG_DW  [NI] = '{8, 8, 8, 4, 5};
    localparam int CFG_CPB [NI] = '{4, 4, 4, 1, 3};
    localparam int CFG_PE  [NI] = '{1, 1, 0, 0, 1};
    localparam int CFG_PO  [NI] = '{0, 1, 0, 0, 1};
    localparam int CFG_SB  [NI] = '{1, 1, 2, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid    [NI];
    logic [7:0] tx_data     [NI];
    logic       serial_out  [NI];
    logic       busy        [NI];
    logic       data_strobe [NI];
    logic       tx_ready    [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic       e_line   [$];
    logic       e_strobe [$];
    logic       e_ready  [$];
    logic [7:0] word_q   [$];
    logic [3:0] rx_sr;

    always #5 clk = ~clk;

    pts_frame_tx #(.DATA_W(CFG_DW[0]), .CLKS_PER_BIT(CFG_CPB[0]), .PARITY_EN(CFG_PE[0]),
                   .PARITY_ODD(CFG_PO[0]), .STOP_BITS(CFG_SB[0])) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .busy(busy[0]),
        .data_strobe(data_strobe[0]));

    pts_frame_tx #(.DATA_W(CFG_DW[1]), .CLKS_PER_BIT(CFG_CPB[1]), .PARITY_EN(CFG_PE[1]),
                   .PARITY_ODD(CFG_PO[1]), .STOP_BITS(CFG_SB[1])) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .busy(busy[1]),
        .data_strobe(data_strobe[1]));

    pts_frame_tx #(.DATA_W(CFG_DW[2]), .CLKS_PER_BIT(CFG_CPB[2]), .PARITY_EN(CFG_PE[2]),
                   .PARITY_ODD(CFG_PO[2]), .STOP_BITS(CFG_SB[2])) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .serial_out(serial_out[2]), .busy(busy[2]),
        .data_strobe(data_strobe[2]));

    pts_frame_tx #(.DATA_W(CFG_DW[3]), .CLKS_PER_BIT(CFG_CPB[3]), .PARITY_EN(CFG_PE[3]),
                   .PARITY_ODD(CFG_PO[3]), .STOP_BITS(CFG_SB[3])) u_dut3 (
        .clk(clk), .rst(rst), .tx_data(tx_data[3][3:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .serial_out(serial_out[3]), .busy(busy[3]),
        .data_strobe(data_strobe[3]));

    pts_frame_tx #(.DATA_W(CFG_DW[4]), .CLKS_PER_BIT(CFG_CPB[4]), .PARITY_EN(CFG_PE[4]),
                   .PARITY_ODD(CFG_PO[4]), .STOP_BITS(CFG_SB[4])) u_dut4 (
        .clk(clk), .rst(rst), .tx_data(tx_data[4][4:0]), .tx_valid(tx_valid[4]),
        .tx_ready(tx_ready[4]), .serial_out(serial_out[4]), .busy(busy[4]),
        .data_strobe(data_strobe[4]));

    // LSB-first shift-in receiver clocked by the 4-bit instance's data_strobe.
    always @(posedge clk) begin
        if (data_strobe[3]) rx_sr <= {serial_out[3], rx_sr[3:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected per-cycle line/strobe/ready for one frame of word w on instance inst.
    task automatic build_frame(input int inst, input logic [7:0] w);
        logic bits [$];
        int   ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < CFG_DW[inst]; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (CFG_PE[inst] != 0) bits.push_back(((ones % 2) == 1) != (CFG_PO[inst] == 1));
        for (int s = 0; s < CFG_SB[inst]; s++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < CFG_CPB[inst]; c++) begin
                e_line.push_back(bits[b]);
                e_strobe.push_back(b >= 1 && b <= CFG_DW[inst] && c == CFG_CPB[inst] - 1);
                e_ready.push_back(b == bits.size() - 1 && c == CFG_CPB[inst] - 1);
            end
        end
    endtask

    // Sends every word in word_q back-to-back; noise toggles tx_valid/tx_data mid-frame.
    task automatic send_burst(input int inst, input bit noise);
        int fl, n_words, j;
        int n_strobe = 0;
        int exp_strobe = 0;
        e_line.delete();
        e_strobe.delete();
        e_ready.delete();
        foreach (word_q[w]) build_frame(inst, word_q[w]);
        n_words = word_q.size();
        fl = e_line.size() / n_words;
        foreach (e_strobe[k]) exp_strobe += int'(e_strobe[k]);

        @(negedge clk);
        check($sformatf("i%0d ready_before", inst), tx_ready[inst], 1);
        tx_valid[inst] = 1'b1;
        tx_data[inst]  = word_q[0];
        for (int k = 0; k < e_line.size(); k++) begin
            @(negedge clk);
            check($sformatf("i%0d line c%0d", inst, k), serial_out[inst], e_line[k]);
            check($sformatf("i%0d busy c%0d", inst, k), busy[inst], 1);
            check($sformatf("i%0d ready c%0d", inst, k), tx_ready[inst], e_ready[k]);
            check($sformatf("i%0d strobe c%0d", inst, k), data_strobe[inst], e_strobe[k]);
            n_strobe += int'(data_strobe[inst]);
            if (k % fl == fl - 1) begin
                j = k / fl;
                tx_valid[inst] = (j + 1 < n_words);
                tx_data[inst]  = (j + 1 < n_words) ? word_q[j + 1] : 8'($urandom);
            end else if (noise) begin
                tx_valid[inst] = 1'($urandom_range(0, 1));
                tx_data[inst]  = 8'($urandom);
            end else begin
                tx_valid[inst] = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("i%0d idle_line", inst), serial_out[inst], 1);
        check($sformatf("i%0d idle_busy", inst), busy[inst], 0);
        check($sformatf("i%0d idle_ready", inst), tx_ready[inst], 1);
        check($sformatf("i%0d strobe_count", inst), n_strobe, exp_strobe);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end
        #12;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d rst_line", i), serial_out[i], 1);
            check($sformatf("i%0d rst_busy", i), busy[i], 0);
            check($sformatf("i%0d rst_ready", i), tx_ready[i], 1);
            check($sformatf("i%0d rst_strobe", i), data_strobe[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single frame, back-to-back pair, odd parity / two stop bits.
        word_q = '{8'hA5};
        send_burst(0, 1'b0);
        word_q = '{8'h3C, 8'hC3};
        send_burst(0, 1'b1);
        word_q = '{8'h00};
        send_burst(1, 1'b0);
        word_q = '{8'hFF};
        send_burst(2, 1'b0);

        // Asynchronous reset in the middle of the third data bit.
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h5A;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        check("rst_mid busy_before", busy[0], 1);
        repeat (13) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid line", serial_out[0], 1);
        check("rst_mid busy", busy[0], 0);
        check("rst_mid ready", tx_ready[0], 1);
        check("rst_mid strobe", data_strobe[0], 0);
        #1 rst = 1'b0;
        word_q = '{8'h5A};
        send_burst(0, 1'b0);

        // Mid-frame noise must not disturb the frame.
        word_q = '{8'hA5};
        send_burst(0, 1'b1);

        // Shift-in receiver on the DATA_W=4, CLKS_PER_BIT=1 instance.
        word_q = '{8'h09};
        send_burst(3, 1'b0);
        check("rx_shift_in 0x9", rx_sr, 4'b1001);

        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NI; i++) begin
                int n_words;
                n_words = $urandom_range(1, 3);
                word_q.delete();
                for (int w = 0; w < n_words; w++) word_q.push_back(8'($urandom));
                send_burst(i, 1'($urandom_range(0, 1)));
                if (i == 3) check("rx_shift_in rand", rx_sr, word_q[n_words - 1][3:0]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
